param_shift_reg: RTL

Parametrised multi-mode shift register, the successor to the single-bit D flip-flop storage element.
- Holds a WIDTH-bit word; supports load, clear, logical/arithmetic shifts and rotates.
- Multi-bit shifts execute one bit per cycle under a start/busy/done handshake.
- Used as the shift/accumulator register in the sequential multiplier/divider datapaths and in serial I/O paths.

---
 rtl/param_shift_reg_pkg.sv | 26 ++
 rtl/param_shift_reg_if.sv | 34 +++
 rtl/param_shift_reg_step.sv | 46 ++++
 rtl/param_shift_reg.sv | 99 +++++++++
 4 files changed

// File: rtl/param_shift_reg_pkg.sv
// Shared op-code constants, FSM state encoding and helpers for param_shift_reg.
package shift_reg_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_HOLD = 3'b000;
   localparam op_t OP_LOAD = 3'b001;
   localparam op_t OP_SHL  = 3'b010;
   localparam op_t OP_SHR  = 3'b011;
   localparam op_t OP_ASR  = 3'b100;
   localparam op_t OP_ROL  = 3'b101;
   localparam op_t OP_ROR  = 3'b110;
   localparam op_t OP_CLR  = 3'b111;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_RUN  = 1'b1;

   // Shift and rotate codes run as multi-cycle step sequences; the rest finish in one edge.
   function automatic logic is_shift_op(input op_t op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) ||
             (op == OP_ROL) || (op == OP_ROR);
   endfunction

endpackage

// File: rtl/param_shift_reg_if.sv
// Command/status bundle between a shift-register user (master) and param_shift_reg (slave).
// PARAM_SHIFT_REG_ABORT_EN adds the abort request line.
interface param_shift_reg_if
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
);

   logic             start;
   op_t              op;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] d;
   logic             sin;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             busy;
   logic             done;

`ifdef PARAM_SHIFT_REG_ABORT_EN
   logic             abort;

   modport master (output start, op, amt, d, sin, abort,
                   input  q, sout, busy, done);
   modport slave  (input  start, op, amt, d, sin, abort,
                   output q, sout, busy, done);
`else
   modport master (output start, op, amt, d, sin,
                   input  q, sout, busy, done);
   modport slave  (input  start, op, amt, d, sin,
                   output q, sout, busy, done);
`endif

endinterface

// File: rtl/param_shift_reg_step.sv
// Single-bit shift/rotate step: next register value and the bit that falls out.
module shift_step_unit
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  op_t              op,
   input  logic             sin,
   output logic [WIDTH-1:0] q_next,
   output logic             out_bit
);

   // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      q_next  = q;
      out_bit = 1'b0;
      case (op)
         OP_SHL: begin
            q_next  = {q[WIDTH-2:0], sin};
            out_bit = q[WIDTH-1];
         end
         OP_SHR: begin
            q_next  = {sin, q[WIDTH-1:1]};
            out_bit = q[0];
         end
         OP_ASR: begin
            q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
            out_bit = q[0];
         end
         OP_ROL: begin
            q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
            out_bit = q[WIDTH-1];
         end
         OP_ROR: begin
            q_next  = {q[0], q[WIDTH-1:1]};
            out_bit = q[0];
         end
         default: begin
            q_next  = q;
            out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/param_shift_reg.sv
// Multi-mode WIDTH-bit shift register: load/clear/hold in one edge, shifts one bit per edge.
// Define PARAM_SHIFT_REG_ABORT_EN to let bus.abort cancel a running shift.
module param_shift_reg
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   param_shift_reg_if.slave bus
);

   localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

   state_t           state;
   op_t              op_run;
   logic [AMT_W-1:0] cnt;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             done;
   logic [WIDTH-1:0] step_q;
   logic             step_out;
   logic             abort_req;

`ifdef PARAM_SHIFT_REG_ABORT_EN
   assign abort_req = bus.abort;
`else
   assign abort_req = 1'b0;
`endif

   // The latched op drives the step unit; sin stays live so serial data streams in per step.
   shift_step_unit #(.WIDTH(WIDTH)) u_step (
      .q       (q),
      .op      (op_run),
      .sin     (bus.sin),
      .q_next  (step_q),
      .out_bit (step_out)
   );

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         op_run <= OP_HOLD;
         cnt    <= '0;
         q      <= '0;
         sout   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  if (is_shift_op(bus.op)) begin
                     if (bus.amt == '0) begin
                        done <= 1'b1;
                     end else begin
                        op_run <= bus.op;
                        cnt    <= bus.amt;
                        state  <= ST_RUN;
                     end
                  end else begin
                     done <= 1'b1;
                     if (bus.op == OP_LOAD) begin
                        q    <= bus.d;
                        sout <= 1'b0;
                     end else if (bus.op == OP_CLR) begin
                        q    <= '0;
                        sout <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               // An abort leaves the partial result in q and suppresses done.
               if (abort_req) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  q    <= step_q;
                  sout <= step_out;
                  cnt  <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign bus.q    = q;
   assign bus.sout = sout;
   assign bus.busy = (state == ST_RUN);
   assign bus.done = done;

endmodule
